// File: rtl/gearbox_ctrl.sv
// gearbox_ctrl: N-speed transmission controller. Tracks the engaged gear from
// manual one-hot switches or, in automatic mode, from RPM up/down thresholds
// with a minimum dwell between automatic shifts. All outputs are registered.
module gearbox_ctrl #(
  parameter int unsigned           NUM_GEARS     = 4,
  parameter int unsigned           RPM_W         = 32,
  parameter int unsigned           RATIO_W       = 8,
  parameter logic [RPM_W-1:0]      UP_RPM        = 'h800000,
  parameter logic [RPM_W-1:0]      DOWN_RPM      = 'h100,
  parameter int unsigned           DWELL         = 16,
  parameter int unsigned           NEUTRAL_RATIO = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 auto_en,
  input  logic [NUM_GEARS-1:0] gear_sel,
  input  logic [RPM_W-1:0]     rpm_val,
  input  logic                 rpm_valid,
  output logic [NUM_GEARS-1:0] gear,
  output logic [RATIO_W-1:0]   gear_ratio,
  output logic [1:0]           shift,
  output logic                 fault
);

  localparam int unsigned CntW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
  localparam logic [NUM_GEARS-1:0] FirstGear = {{(NUM_GEARS-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0] DwellLoad = CntW'(DWELL);

  typedef enum logic [1:0] {
    StNeutral,
    StManual,
    StAutoDwell,
    StAutoReady
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_GEARS-1:0] gear_q, gear_d;
  logic [RATIO_W-1:0]   ratio_q, ratio_d;
  logic [1:0]           shift_q, shift_d;
  logic                 fault_q, fault_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic sel_zero;
  logic sel_onehot;

  assign sel_zero   = (gear_sel == '0);
  assign sel_onehot = !sel_zero && ((gear_sel & (gear_sel - 1'b1)) == '0);

  // State register; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StNeutral;
      gear_q  <= '0;
      ratio_q <= RATIO_W'(NEUTRAL_RATIO);
      shift_q <= 2'b00;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gear_q  <= gear_d;
      ratio_q <= ratio_d;
      shift_q <= shift_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: manual mode always takes priority over the auto FSM.
  always_comb begin
    state_d = state_q;
    gear_d  = gear_q;
    cnt_d   = cnt_q;
    shift_d = 2'b00;
    fault_d = 1'b0;

    if (!auto_en) begin
      cnt_d = '0;
      if (sel_onehot) begin
        gear_d  = gear_sel;
        state_d = StManual;
      end else begin
        gear_d  = '0;
        state_d = StNeutral;
        fault_d = !sel_zero;
      end
    end else begin
      unique case (state_q)
        StNeutral, StManual: begin
          // Auto entry keeps a manually engaged gear, otherwise starts in gear 1.
          if (gear_q == '0) gear_d = FirstGear;
          cnt_d   = DwellLoad;
          state_d = (DWELL == 0) ? StAutoReady : StAutoDwell;
        end
        StAutoDwell: begin
          if (cnt_q <= CntW'(1)) begin
            cnt_d   = '0;
            state_d = StAutoReady;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StAutoReady: begin
          if (rpm_valid) begin
            if ((rpm_val >= UP_RPM) && !gear_q[NUM_GEARS-1]) begin
              gear_d  = gear_q << 1;
              shift_d = 2'b01;
              cnt_d   = DwellLoad;
              state_d = (DWELL == 0) ? StAutoReady : StAutoDwell;
            end else if ((rpm_val <= DOWN_RPM) && !gear_q[0]) begin
              gear_d  = gear_q >> 1;
              shift_d = 2'b10;
              cnt_d   = DwellLoad;
              state_d = (DWELL == 0) ? StAutoReady : StAutoDwell;
            end
          end
        end
        default: begin
          state_d = StNeutral;
          gear_d  = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Ratio lookup from the next gear so the registered ratio tracks gear exactly.
  always_comb begin
    ratio_d = RATIO_W'(NEUTRAL_RATIO);
    for (int i = 0; i < int'(NUM_GEARS); i++) begin
      if (gear_d[i]) ratio_d = RATIO_W'(int'(NUM_GEARS) - i);
    end
  end

  assign gear       = gear_q;
  assign gear_ratio = ratio_q;
  assign shift      = shift_q;
  assign fault      = fault_q;

endmodule

// File: doc/gearbox_ctrl.md
# gearbox_ctrl

Parametrised N-speed transmission controller for the drivetrain model. It takes the measured engine RPM and the driver gear switches and maintains the current gear, which is selected manually or automatically from RPM thresholds. It outputs the gear ratio and a one-cycle shift indication to the RPM/speed model. Compared with the fixed 4-speed block, it adds:
- a configurable gear count and thresholds;
- an explicit auto-mode input;
- an RPM valid qualifier;
- a post-shift dwell timer;
- illegal-selection fault reporting.

## Interface

Parameters:
- NUM_GEARS, 4: number of forward gears, 2..15
- RPM_W, 32: width of the RPM sample
- RATIO_W, 8: width of the gear ratio output
- UP_RPM, 32'h800000: upshift threshold, inclusive (rpm >= UP_RPM)
- DOWN_RPM, 32'h100: downshift threshold, inclusive (rpm <= DOWN_RPM)
- DWELL, 16: minimum cycles between automatic shifts; 0 allows a shift every cycle
- NEUTRAL_RATIO, 25: ratio output when no gear is engaged

Ports:
- clk, input, 1: clock; all state is updated on the rising edge
- reset, input, 1: synchronous, active-high
- auto_en, input, 1: 1 selects automatic mode, 0 selects manual mode
- gear_sel, input, NUM_GEARS: manual gear switches, one-hot; bit i selects gear i+1
- rpm_val, input, RPM_W: current engine RPM
- rpm_valid, input, 1: rpm_val is meaningful this cycle
- gear, output, NUM_GEARS: engaged gear, one-hot; all zeros means neutral
- gear_ratio, output, RATIO_W: ratio for the engaged gear
- shift, output, 2: 01 = upshift, 10 = downshift, 00 = none; one-cycle pulse
- fault, output, 1: manual selection is multi-hot

## Operation

- The ratio table is fixed: gear k (1..NUM_GEARS) has ratio NUM_GEARS+1-k, so gear 1 has the highest ratio. Neutral has ratio NEUTRAL_RATIO.
- gear, gear_ratio, shift and fault are all registered. gear_ratio is always consistent with gear in the same cycle.
- State machine states: NEUTRAL, MANUAL, AUTO_DWELL, AUTO_READY. An internal dwell counter is sized $clog2(DWELL+1), with a minimum of 1 bit.

Reset:
- state = NEUTRAL, gear = 0, gear_ratio = NEUTRAL_RATIO, shift = 00, fault = 0, dwell counter = 0.

Manual mode (auto_en = 0), from any state:
- gear_sel is exactly one-hot: gear = gear_sel, state = MANUAL, fault = 0.
- gear_sel is zero: gear = 0 (NEUTRAL), fault = 0.
- gear_sel is multi-hot: gear = 0 (NEUTRAL), fault = 1.
- In all manual cases, shift = 00 and the dwell counter is cleared.

Automatic mode entry (auto_en 0→1, i.e. the state is NEUTRAL or MANUAL):
- If gear is nonzero, it is kept; otherwise gear = gear 1.
- dwell counter = DWELL. State goes to AUTO_DWELL, or directly to AUTO_READY when DWELL = 0.
- shift = 00 and fault = 0.

AUTO_DWELL:
- The counter decrements each cycle. No shift is taken regardless of rpm.
- When the counter reaches 0, the state goes to AUTO_READY.

AUTO_READY, while rpm_valid = 1:
- rpm_val >= UP_RPM and gear is not the top gear: shift the gear one position up, shift = 01.
- Otherwise, rpm_val <= DOWN_RPM and gear is not gear 1: shift the gear one position down, shift = 10.
- After either shift, the counter is reloaded with DWELL and the state goes to AUTO_DWELL (or stays in AUTO_READY when DWELL = 0).
- If both thresholds are met because of misconfiguration, the upshift wins.

Saturation:
- At the top gear with rpm >= UP_RPM, or at gear 1 with rpm <= DOWN_RPM, the gear is unchanged, shift = 00 and the counter is not reloaded.

rpm_valid = 0 in AUTO_READY:
- No action and shift = 00. The dwell counter still runs in AUTO_DWELL regardless of rpm_valid.

Return to manual:
- auto_en 1→0 takes effect on the next edge. It follows the manual rules, so any pending shift is abandoned.

Comparisons are unsigned and RPM_W wide.

## Timing

- Inputs sampled at edge N produce updated gear, gear_ratio, shift and fault after edge N: 1-cycle latency.
- shift is high for exactly one cycle per gear change and is never asserted in manual mode.
- Dwell spacing: a shift registered at edge N means the next automatic shift is possible no earlier than edge N+DWELL+1.
- reset asserted at any edge wins over every other input, including mid-dwell and at a shift edge. The reset values are visible after that edge.
- After reset deasserts with auto_en = 1: the first edge is the automatic-mode entry (gear 1, dwell loaded), not a shift.

## Test plan

All scenarios use NUM_GEARS = 4, DWELL = 4, UP_RPM = 'h800000, DOWN_RPM = 'h100.

1. Reset, then manual gear_sel = 0010 → gear = 0010, ratio = 3, shift = 00. Then gear_sel = 0110 → gear = 0, ratio = 25, fault = 1.
2. auto_en = 1 from NEUTRAL, rpm = 'h900000 valid every cycle → entry at edge E. Upshifts at E+5, E+10 and E+15, each with a single-cycle shift = 01. Ratio steps 4→3→2→1. After that there are no further shifts at top gear.
3. Auto mode in gear 4, rpm = 'h80 valid → downshifts spaced 5 cycles apart to gear 1 with shift = 10. Gear then saturates at 0001 with shift = 00.
4. Auto mode in AUTO_READY at gear 2, rpm = 'h900000 with rpm_valid = 0 for 10 cycles → no shift. Assert rpm_valid → upshift on the next edge.
5. Auto mode with the manual switches at 0100: switch auto_en 1→0 during AUTO_DWELL → next cycle gear = 0100, shift = 00, and the counter is cleared.
6. Assert reset on the same edge an upshift would occur → gear = 0, ratio = 25, shift = 00, with no shift pulse ever seen.
